// File: rtl/regfile_scan_ctrl_pkg.sv
// Shared definitions for the serial register-file debug access controller.
//   WORD_LENGTH : default register width (data frame length in bits)
//   CMD_READ / CMD_WRITE : values of the frame's leading command bit
//   state_t     : controller FSM states, also exported on the debug port
package regfile_scan_ctrl_pkg;

    localparam int WORD_LENGTH = 32;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        ADDR  = 3'd2,
        WDATA = 3'd3,
        ARB   = 3'd4,
        XFER  = 3'd5,
        RDATA = 3'd6,
        DONE  = 3'd7
    } state_t;

endpackage

// File: rtl/regfile_scan_ctrl_shift.sv
// scan_shift_reg: WIDTH-bit data register with parallel load and
// shift-right (serial in at the MSB, serial out from the LSB).
//   clk, rst       : clock, asynchronous active-low reset (clears q)
//   load/load_data : parallel load, takes priority over shift
//   shift/sin      : shift right one place, sin enters at bit WIDTH-1
//   q / sout       : register contents / current LSB
module scan_shift_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {sin, q[WIDTH-1:1]};
        end
    end

    assign sout = q[0];

endmodule

// File: rtl/regfile_scan_ctrl.sv
// regfile_scan_ctrl: bit-serial debug access controller for a register file.
// A frame is 1 command bit, ADDR_W address bits and (for writes) WIDTH data
// bits, all LSB first. The controller then requests the file port from the
// core, commits the write or captures the read word, and for reads shifts
// the word back out LSB first.
//   clk, rst            : clock, asynchronous active-low reset
//   sEnable             : frame enable (rising edge starts, low aborts/ends)
//   sValid / sIn        : bit strobe / serial data in
//   sOut / sReady       : serial read data out / controller takes a bit now
//   sErr                : sticky strobe-while-not-ready flag, cleared per frame
//   done                : one-cycle pulse when a frame completes
//   regReq / regGnt     : file port request / grant from the core
//   rfRead*, rfWrite*   : register file read and write port
//   dbg_state           : current FSM state
//
// Serial handshake: a bit is transferred on a clock edge where both sValid
// and sReady are high; sValid while sReady is low drops the bit and sets
// sErr (except in IDLE, where strobes are simply ignored).
module regfile_scan_ctrl
    import regfile_scan_ctrl_pkg::*;
#(
    parameter  int SIZE   = 16,
    parameter  int WIDTH  = WORD_LENGTH,
    localparam int ADDR_W = $clog2(SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sEnable,
    input  logic              sValid,
    input  logic              sIn,
    output logic              sOut,
    output logic              sReady,
    output logic              sErr,
    output logic              done,
    output logic              regReq,
    input  logic              regGnt,
    output logic [ADDR_W-1:0] rfReadAddr,
    input  logic [WIDTH-1:0]  rfReadData,
    output logic              rfWriteEnable,
    output logic [ADDR_W-1:0] rfWriteAddr,
    output logic [WIDTH-1:0]  rfWriteData,
    output state_t            dbg_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    logic               en_q;
    logic               cmd_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [CNT_W-1:0]   cnt;
    logic               err_q;
    logic               done_q;

    logic               rise;
    logic               ready;
    logic               addr_last;
    logic               data_last;
    logic               data_load;
    logic               data_shift;
    logic               data_sin;
    logic [WIDTH-1:0]   data_q;
    logic               data_sout;

    assign rise      = sEnable & ~en_q;
    assign ready     = (state == CMD) || (state == ADDR) ||
                       (state == WDATA) || (state == RDATA);
    assign addr_last = (cnt == CNT_W'(ADDR_W - 1));
    assign data_last = (cnt == CNT_W'(WIDTH - 1));

    // The data register assembles write data, captures read data in XFER
    // and drains it (zero-filled) during readout.
    assign data_load  = (state == XFER) && (cmd_q == CMD_READ);
    assign data_shift = sValid && ((state == WDATA) || (state == RDATA));
    assign data_sin   = (state == WDATA) ? sIn : 1'b0;

    scan_shift_reg #(.WIDTH(WIDTH)) u_data (
        .clk       (clk),
        .rst       (rst),
        .load      (data_load),
        .load_data (rfReadData),
        .shift     (data_shift),
        .sin       (data_sin),
        .q         (data_q),
        .sout      (data_sout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            en_q   <= 1'b0;
            cmd_q  <= 1'b0;
            addr_q <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            en_q   <= sEnable;
            done_q <= 1'b0;
            if ((state != IDLE) && sValid && !ready) begin
                err_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rise) begin
                        state <= CMD;
                        err_q <= 1'b0;
                    end
                end
                CMD: begin
                    if (!sEnable) begin
                        state <= IDLE;
                    end else if (sValid) begin
                        cmd_q <= sIn;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (!sEnable) begin
                        state <= IDLE;
                    end else if (sValid) begin
                        addr_q <= {sIn, addr_q[ADDR_W-1:1]};
                        if (addr_last) begin
                            cnt   <= '0;
                            state <= (cmd_q == CMD_WRITE) ? WDATA : ARB;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                WDATA: begin
                    if (!sEnable) begin
                        state <= IDLE;
                    end else if (sValid) begin
                        if (data_last) begin
                            cnt   <= '0;
                            state <= ARB;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ARB: begin
                    if (!sEnable) begin
                        state <= IDLE;
                    end else if (regGnt) begin
                        state <= XFER;
                    end
                end
                XFER: begin
                    // The port access always completes; a dropped enable
                    // only skips the readout and goes straight to DONE.
                    if (!sEnable || (cmd_q == CMD_WRITE)) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        state <= RDATA;
                    end
                end
                RDATA: begin
                    if (!sEnable) begin
                        state <= IDLE;
                    end else if (sValid) begin
                        if (data_last) begin
                            cnt    <= '0;
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!sEnable) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sReady        = ready;
    assign sOut          = (state == RDATA) & data_sout;
    assign sErr          = err_q;
    assign done          = done_q;
    assign regReq        = (state == ARB) || (state == XFER);
    assign rfWriteEnable = (state == XFER) && (cmd_q == CMD_WRITE);
    assign rfReadAddr    = addr_q;
    assign rfWriteAddr   = addr_q;
    assign rfWriteData   = data_q;
    assign dbg_state     = state;

endmodule
